// File: rtl/run_step_pkg.sv
// Shared types for the run/halt/single-step controller.
// Provides the FSM state encoding and the idle level of the active-low buttons.
package run_step_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam logic BTN_IDLE = 1'b1;

  // Counter width for a debouncer: wide enough to hold DEB_CYCLES-1,
  // never narrower than one bit.
  function automatic int deb_cnt_w(input int deb);
    return (deb > 1) ? $clog2(deb) : 1;
  endfunction

endpackage

// File: rtl/run_step_ctrl_btn_press_l.sv
// btn_press_l: synchroniser + debounce + one-shot press pulse for an active-low button.
// Ports: clk_i, rst_i (async high), btn_l_i (async button), press_o (1-cycle pulse).
module btn_press_l
  import run_step_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_l_i,
  output logic press_o
);

  localparam int CNTW = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNTW-1:0] CMAX = CNTW'(DEB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            fired_q;
  logic            fired_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= BTN_IDLE;
      sync2_q <= BTN_IDLE;
    end else begin
      sync1_q <= btn_l_i;
      sync2_q <= sync1_q;
    end
  end

  // cnt_q holds how many earlier cycles the synchronised level has
  // been low (saturating); the current low cycle completes the window.
  assign press_o = ~sync2_q & (cnt_q == CMAX) & ~fired_q;

  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    if (sync2_q) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else begin
      if (cnt_q != CMAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      // A held button must go high again before re-arming.
      if (press_o) begin
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

endmodule

// File: rtl/run_step_ctrl.sv
// run_step_ctrl: processor run/halt/single-step controller driving HOLD.
// Ports: CLK, RST (async high), HALT_REQ, STEP_L, RUN_L, STEP_COUNT, PC,
//   BP_ADDR, BP_VALID in; HOLD, STATE, STEP_LEFT, BP_HIT out.
// Build option: RUN_STEP_BREAKPOINT_EN enables the PC breakpoint.
module run_step_ctrl
  import run_step_pkg::*;
#(
  parameter int CW           = 4,
  parameter int AW           = 32,
  parameter int DEB_CYCLES   = 4,
  parameter int RESET_HALTED = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HALT_REQ,
  input  logic          STEP_L,
  input  logic          RUN_L,
  input  logic [CW-1:0] STEP_COUNT,
  input  logic [AW-1:0] PC,
  input  logic [AW-1:0] BP_ADDR,
  input  logic          BP_VALID,
  output logic          HOLD,
  output logic [1:0]    STATE,
  output logic [CW-1:0] STEP_LEFT,
  output logic          BP_HIT
);

  localparam state_t RST_STATE = (RESET_HALTED != 0) ? HALTED : RUN;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] step_q;
  logic [CW-1:0] step_d;
  logic          mask_q;
  logic          mask_d;
  logic          bphit_q;
  logic          bphit_d;

  logic step_pulse;
  logic run_pulse;
  logic bp_match;
  logic stop_req;

  btn_press_l #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_btn (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_l_i(STEP_L),
    .press_o(step_pulse)
  );

  btn_press_l #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_run_btn (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_l_i(RUN_L),
    .press_o(run_pulse)
  );

`ifdef RUN_STEP_BREAKPOINT_EN
  assign bp_match = BP_VALID & (PC == BP_ADDR);
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{PC, BP_ADDR, BP_VALID};
`endif

  // The mask lets the instruction that caused the halt retire once
  // on resume instead of re-halting immediately.
  assign stop_req = (HALT_REQ | bp_match) & ~mask_q;

  assign HOLD = (state_q == HALTED)
              | ((state_q == RUN) & stop_req);

  assign STATE     = state_q;
  assign STEP_LEFT = step_q;
  assign BP_HIT    = bphit_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mask_d  = 1'b0;
    bphit_d = bphit_q;
    case (state_q)
      RUN: begin
        if (stop_req) begin
          state_d = HALTED;
          bphit_d = bp_match;
        end
      end
      HALTED: begin
        if (run_pulse) begin
          state_d = RUN;
          mask_d  = 1'b1;
          bphit_d = 1'b0;
        end else if (step_pulse) begin
          state_d = STEP;
          step_d  = (STEP_COUNT == '0) ? CW'(1) : STEP_COUNT;
          bphit_d = 1'b0;
        end
      end
      STEP: begin
        if (step_q <= CW'(1)) begin
          state_d = HALTED;
          step_d  = '0;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      default: begin
        state_d = HALTED;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RST_STATE;
      step_q  <= '0;
      mask_q  <= 1'b0;
      bphit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mask_q  <= mask_d;
      bphit_q <= bphit_d;
    end
  end

endmodule
